// File: rtl/seq_alu.sv
// Registered ALU with a valid/ready handshake on both sides: single-cycle logic/arith ops
// plus a fixed-latency iterative shift-add multiply (low WIDTH bits of the product).
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o
);

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_MUL = 4'd3,
        OP_SUB = 4'd6,
        OP_SLT = 4'd7,
        OP_SRA = 4'd8,
        OP_LUI = 4'd9,
        OP_BNE = 4'd10,
        OP_NOR = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam int MSB = WIDTH - 1;

    op_e              op;
    state_e           state_q, state_d;
    logic             accept;
    logic             is_mul;
    logic             last_step;

    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_zero;

    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [WIDTH-1:0] acc_step;
    logic [SHAMT_W-1:0] count_q;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    assign op     = op_e'(ctrl_i);
    assign is_mul = (op == OP_MUL);

    // Handshake: ready depends only on state and the downstream ready, never on valid_i.
    assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept  = valid_i && ready_o;

    assign sum  = src1_i + src2_i;
    assign diff = src1_i - src2_i;

    // NOTE: every always_comb output gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = src1_i & src2_i;
            OP_OR:  alu_res = src1_i | src2_i;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1_i[MSB] == src2_i[MSB]) && (sum[MSB] != src1_i[MSB]);
            end
            OP_SUB, OP_BNE: begin
                alu_res = diff;
                alu_ovf = (src1_i[MSB] != src2_i[MSB]) && (diff[MSB] != src1_i[MSB]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            OP_SRA: alu_res = $signed(src1_i) >>> src2_i[SHAMT_W-1:0];
            OP_LUI: alu_res = src2_i << (WIDTH / 2);
            OP_NOR: alu_res = ~(src1_i | src2_i);
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // BNE inverts the sense of the zero flag so the branch unit can use it unchanged.
    assign alu_zero = (alu_res == '0) ^ (op == OP_BNE);

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (count_q == SHAMT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = is_mul ? BUSY : DONE;
            end
            BUSY: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                if (accept)       state_d = is_mul ? BUSY : DONE;
                else if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                mcand_q  <= src1_i;
                mplier_q <= src2_i;
                acc_q    <= '0;
                count_q  <= '0;
            end else begin
                result_q <= alu_res;
                zero_q   <= alu_zero;
                ovf_q    <= alu_ovf;
            end
        end else if (state_q == BUSY) begin
            // Fixed WIDTH iterations; a zero multiplier does not finish early.
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + SHAMT_W'(1);
            if (last_step) begin
                result_q <= acc_step;
                zero_q   <= (acc_step == '0);
                ovf_q    <= 1'b0;
            end
        end
    end

    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: one 32-bit and one 16-bit instance share the stimulus,
// selected by width_sel, with hand-computed expected results.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid;
    logic        ready_in;
    logic [31:0] src1, src2;
    logic [3:0]  ctrl;
    logic        width_sel;   // 0: 32-bit instance, 1: 16-bit instance

    logic        r32_ready, r32_valid, r32_zero, r32_ovf;
    logic [31:0] r32_result;
    logic        r16_ready, r16_valid, r16_zero, r16_ovf;
    logic [15:0] r16_result;

    logic        m_ready, m_valid, m_zero, m_ovf;
    logic [31:0] m_result;

    int passed = 0;
    int total  = 0;

    seq_alu #(.WIDTH(32)) u_alu32 (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid && !width_sel),
        .ready_o  (r32_ready),
        .src1_i   (src1),
        .src2_i   (src2),
        .ctrl_i   (ctrl),
        .valid_o  (r32_valid),
        .ready_i  (ready_in),
        .result_o (r32_result),
        .zero_o   (r32_zero),
        .ovf_o    (r32_ovf)
    );

    seq_alu #(.WIDTH(16)) u_alu16 (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid && width_sel),
        .ready_o  (r16_ready),
        .src1_i   (src1[15:0]),
        .src2_i   (src2[15:0]),
        .ctrl_i   (ctrl),
        .valid_o  (r16_valid),
        .ready_i  (ready_in),
        .result_o (r16_result),
        .zero_o   (r16_zero),
        .ovf_o    (r16_ovf)
    );

    assign m_ready  = width_sel ? r16_ready  : r32_ready;
    assign m_valid  = width_sel ? r16_valid  : r32_valid;
    assign m_zero   = width_sel ? r16_zero   : r32_zero;
    assign m_ovf    = width_sel ? r16_ovf    : r32_ovf;
    assign m_result = width_sel ? {16'h0, r16_result} : r32_result;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else             passed++;
    endtask

    // Present one op at a negedge; it is accepted at the next posedge. Returns at the next negedge.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1;
        ctrl  = c;
        src1  = a;
        src2  = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic z, input logic o);
        check({tag, ".valid"},  {31'h0, m_valid}, 32'd1);
        check({tag, ".result"}, m_result, res);
        check({tag, ".zero"},   {31'h0, m_zero}, {31'h0, z});
        check({tag, ".ovf"},    {31'h0, m_ovf},  {31'h0, o});
    endtask

    // Issue a MUL and measure cycles from the accepting edge to the first valid_o.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output bit ready_stayed_low);
        issue(4'd3, a, b);
        lat = 1;
        ready_stayed_low = 1'b1;
        while (!m_valid && lat < 100) begin
            if (m_ready) ready_stayed_low = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int  lat;
        bit  rdy_low;
        bit  late_valid;

        rst_i     = 1'b0;
        valid     = 1'b0;
        ready_in  = 1'b0;
        src1      = '0;
        src2      = '0;
        ctrl      = '0;
        width_sel = 1'b0;

        repeat (2) @(negedge clk);
        check("rst.valid",  {31'h0, m_valid}, 32'd0);
        check("rst.result", m_result, 32'h0);
        check("rst.zero",   {31'h0, m_zero}, 32'd0);
        check("rst.ovf",    {31'h0, m_ovf},  32'd0);
        check("rst.ready",  {31'h0, m_ready}, 32'd1);
        rst_i    = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);

        // 32-bit single-cycle ops, issued back-to-back with ready_i held high.
        issue(4'd2, 32'h7FFF_FFFF, 32'h1);       check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
        issue(4'd6, 32'h8000_0000, 32'h1);       check_out("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);
        issue(4'd10, 32'd5, 32'd5);              check_out("bne_eq",  32'h0,         1'b0, 1'b0);
        issue(4'd10, 32'd5, 32'd6);              check_out("bne_ne",  32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(4'd6, 32'd5, 32'd5);               check_out("sub_eq",  32'h0,         1'b1, 1'b0);
        issue(4'd8, 32'h8000_0000, 32'h24);      check_out("sra",     32'hF800_0000, 1'b0, 1'b0);
        issue(4'd9, 32'hDEAD_BEEF, 32'h1234);    check_out("lui",     32'h1234_0000, 1'b0, 1'b0);
        issue(4'd7, 32'd3, 32'd5);               check_out("slt_lt",  32'h1,         1'b0, 1'b0);
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);       check_out("slt_uns", 32'h0,         1'b1, 1'b0);
        issue(4'd1, 32'hF0F0, 32'h0F00);         check_out("or",      32'hFFF0,      1'b0, 1'b0);
        issue(4'd12, 32'hFFFF_FFFF, 32'h0);      check_out("nor",     32'h0,         1'b1, 1'b0);
        issue(4'd2, 32'h7FFF_FFFF, 32'h1);
        issue(4'd4, 32'd5, 32'd6);               check_out("undef",   32'h0,         1'b1, 1'b0);

        // MUL: fixed latency WIDTH+1, ready_o low throughout BUSY.
        run_mul(32'h0000_FFFF, 32'h0001_0001, lat, rdy_low);
        check("mul32.latency", lat, 32'd33);
        check("mul32.ready_low", {31'h0, rdy_low}, 32'd1);
        check_out("mul32", 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);

        // Backpressure: result must hold while ready_i is low.
        ready_in = 1'b0;
        issue(4'd0, 32'hF0F0, 32'hFF00);
        for (int i = 0; i < 5; i++) begin
            check("bp.result", m_result, 32'hF000);
            check("bp.valid",  {31'h0, m_valid}, 32'd1);
            check("bp.ready",  {31'h0, m_ready}, 32'd0);
            @(negedge clk);
        end
        ready_in = 1'b1;
        valid    = 1'b1;
        ctrl     = 4'd2;
        src1     = 32'd2;
        src2     = 32'd3;
        #1;
        check("bp.accept_same_cycle", {31'h0, m_ready}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
        check_out("bp.add", 32'd5, 1'b0, 1'b0);

        // Reset in the middle of a MUL (count == 10): op discarded, no late valid.
        issue(4'd3, 32'h1234, 32'h5678);
        repeat (10) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_busy.valid",  {31'h0, m_valid}, 32'd0);
        check("rst_busy.result", m_result, 32'h0);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("rst_busy.ready", {31'h0, m_ready}, 32'd1);
        late_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_valid) late_valid = 1'b1;
        end
        check("rst_busy.no_late_valid", {31'h0, late_valid}, 32'd0);
        run_mul(32'd3, 32'd7, lat, rdy_low);
        check("mul_3x7.latency", lat, 32'd33);
        check_out("mul_3x7", 32'd21, 1'b0, 1'b0);
        @(negedge clk);

        // 16-bit instance.
        width_sel = 1'b1;
        @(negedge clk);
        issue(4'd2, 32'h7FFF, 32'h1);            check_out("w16.add_ovf", 32'h8000, 1'b0, 1'b1);
        issue(4'd8, 32'h8000, 32'h14);           check_out("w16.sra",     32'hF800, 1'b0, 1'b0);
        issue(4'd9, 32'h0, 32'hAB12);            check_out("w16.lui",     32'h1200, 1'b0, 1'b0);
        run_mul(32'h00FF, 32'h0101, lat, rdy_low);
        check("w16.mul.latency", lat, 32'd17);
        check("w16.mul.ready_low", {31'h0, rdy_low}, 32'd1);
        check_out("w16.mul", 32'hFFFF, 1'b0, 1'b0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
